// File: rtl/mul_seq_ctrl.sv
// Sequential radix-2 shift-add multiplier with sign fix-up and NZCV flag update.
// Optional MUL_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are zero.
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             S,
    input  logic [3:0]       Flag,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       New_Flag
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               sgn;
    logic [3:0]         flag_q;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   acc_nxt;
    logic [CW-1:0]      cnt_nxt;
    logic               last;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   hi;
    logic [3:0]         nf;

    assign Busy = (state != IDLE);

    assign mag1 = (S && In1[WIDTH-1]) ? -In1 : In1;
    assign mag2 = (S && In2[WIDTH-1]) ? -In2 : In2;

    // acc[2*WIDTH] is the carry slot; it is always zero again after the shift
    assign addend  = mplier[0] ? mcand : {WIDTH{1'b0}};
    assign sum     = acc[2*WIDTH:WIDTH] + {1'b0, addend};
    assign acc_nxt = {sum, acc[WIDTH-1:0]} >> 1;
    assign cnt_nxt = cnt + 1'b1;

`ifdef MUL_EARLY_EXIT_EN
    assign last     = ((mplier >> 1) == {WIDTH{1'b0}});
    // Partial product sits WIDTH-cnt bits too high when RUN ends early
    assign prod_raw = acc[2*WIDTH-1:0] >> (CW'(WIDTH) - cnt);
`else
    assign last     = (cnt_nxt == CW'(WIDTH));
    assign prod_raw = acc[2*WIDTH-1:0];
`endif

    assign prod = neg ? -prod_raw : prod_raw;
    assign res  = prod[WIDTH-1:0];
    assign hi   = prod[2*WIDTH-1:WIDTH];

    always_comb begin
        nf    = 4'b0000;
        nf[3] = res[WIDTH-1];
        nf[2] = (res == {WIDTH{1'b0}});
        if (sgn) begin
            nf[1] = flag_q[1];
            nf[0] = (hi != {WIDTH{res[WIDTH-1]}});
        end else begin
            nf[1] = (hi != {WIDTH{1'b0}});
            nf[0] = flag_q[0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            sgn      <= 1'b0;
            flag_q   <= 4'b0000;
            Done     <= 1'b0;
            Result   <= '0;
            New_Flag <= 4'b0000;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand  <= mag1;
                        mplier <= mag2;
                        neg    <= S & (In1[WIDTH-1] ^ In2[WIDTH-1]);
                        sgn    <= S;
                        flag_q <= Flag;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt_nxt;
                    if (last) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Result   <= res;
                    New_Flag <= nf;
                    Done     <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
